rvtu_completion_poller: RTL
===========================

// Module: rvtu_completion_poller
// PURPOSE
//  Hardware replacement for bench-side done polling: after start, sweeps NUM_CH RVTU completion CSRs
//  over a valid/ready read port, latches per-channel done, and runs a kernel watchdog.
//  Sits between the top-level control path and the CSR bus. Reports all-done or timeout with elapsed cycles.
// PARAMETERS
//  NUM_CH        2          number of RVTU channels polled (1..16)
//  ADDR_W        32         CSR address width
//  DATA_W        32         CSR read data width; bit0 = channel completion flag
//  CSR_BASE      32'h0      address of channel 0 completion CSR
//  CSR_STRIDE    32'h4      address step between channel completion CSRs
//  POLL_GAP      1000       idle cycles between sweeps (>=1)
//  TMO_W         32         watchdog / cycle counter width
// PORTS
//  clk            in   1        clock
//  rst_n          in   1        asynchronous active-low reset
//  start          in   1        1-cycle pulse: begin polling; ignored unless busy=0
//  tmo_cfg        in   TMO_W    watchdog load value, sampled on accepted start
//  rd_req_vld     out  1        CSR read request valid
//  rd_req_rdy     in   1        CSR read request ready
//  rd_req_addr    out  ADDR_W   CSR_BASE + ch*CSR_STRIDE
//  rd_rsp_vld     in   1        read response valid (one per accepted request, in order)
//  rd_rsp_data    in   DATA_W   read response data
//  busy           out  1        poller active (not IDLE/DONE/TMO)
//  ch_done        out  NUM_CH   sticky per-channel done flags
//  all_done       out  1        all channels done (sticky until next start)
//  tmo_err        out  1        watchdog expired (sticky until next start)
//  elapsed        out  TMO_W    cycles from accepted start to DONE/TMO, saturating
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0.
//  States: IDLE, ISSUE, WAIT_RSP, GAP, DONE, TMO.
//  IDLE/DONE/TMO + start: ch_done<=0, all_done<=0, tmo_err<=0, elapsed<=0, wdog<=tmo_cfg, idx<=0 -> ISSUE.
//  ISSUE: rd_req_vld=1, addr for idx; vld/addr held stable until rd_req_rdy; on handshake -> WAIT_RSP.
//  WAIT_RSP: on rd_rsp_vld, rd_rsp_data[0]=1 sets ch_done[idx]. Next idx = lowest not-done channel above idx.
//   If every channel now done -> DONE (all_done=1 next cycle). Else if next exists -> ISSUE; else -> GAP.
//  GAP: counts POLL_GAP cycles, then ISSUE at lowest not-done channel.
//  Done channels are never re-read within a run. One outstanding request max.
//  Watchdog: decrements each cycle while busy. At 0: from GAP -> TMO immediately; from ISSUE/WAIT_RSP
//   the in-flight transaction completes (handshake + response consumed, ch_done still updated) then TMO.
//   If that final response completes all channels, DONE wins; tmo_err stays 0.
//  tmo_cfg=0: first ISSUE still completes its transaction, then TMO (unless it finishes all channels).
//  elapsed increments each busy cycle, saturates at all-ones, frozen in DONE/TMO.
//  start while busy: ignored. rd_rsp_vld outside WAIT_RSP: ignored.
//  rst_n low mid-run: immediate return to reset values; rd_req_vld drops asynchronously.
//  Latency: start -> rd_req_vld = 1 cycle; rsp with final done -> all_done = 1 cycle.
// TESTING
//  NUM_CH=2, rdy=1, ch0 rsp 1 / ch1 rsp 1 on first sweep -> addrs 0x0,0x4; all_done=1, tmo_err=0.
//  ch0 done on sweep 1, ch1 done on sweep 3 -> sweeps 2,3 read only 0x4; GAP=1000 cycles between sweeps.
//  tmo_cfg=50, responses always 0, POLL_GAP=1000 -> tmo_err=1 in GAP, elapsed=50, no further requests.
//  rd_req_rdy low 20 cycles, wdog expires while ISSUE -> vld/addr held, request + response complete, then TMO.
//  start pulse while busy, and stray rd_rsp_vld in GAP -> no state change, ch_done unchanged.
//  rst_n asserted in WAIT_RSP -> all outputs 0; subsequent start runs a clean full sweep from ch0.

Source files
------------

// File: rtl/rvtu_completion_poller.sv
// rvtu_completion_poller: sweeps per-channel RVTU completion CSRs after start, latching done flags
// and enforcing a kernel watchdog; reports all-done or timeout with elapsed cycles.
module rvtu_completion_poller #(
   parameter int                NUM_CH     = 2,
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter logic [ADDR_W-1:0] CSR_BASE   = 32'h0,
   parameter logic [ADDR_W-1:0] CSR_STRIDE = 32'h4,
   parameter int                POLL_GAP   = 1000,
   parameter int                TMO_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [TMO_W-1:0]  tmo_cfg,
   output logic              rd_req_vld,
   input  logic              rd_req_rdy,
   output logic [ADDR_W-1:0] rd_req_addr,
   input  logic              rd_rsp_vld,
   input  logic [DATA_W-1:0] rd_rsp_data,
   output logic              busy,
   output logic [NUM_CH-1:0] ch_done,
   output logic              all_done,
   output logic              tmo_err,
   output logic [TMO_W-1:0]  elapsed
);
   localparam int IDX_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int GAP_W = $clog2(POLL_GAP + 1);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_GAP   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_TMO   = 3'd5;
   logic [2:0]        state, state_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt, lo_free, above_free;
   logic [GAP_W-1:0]  gap_cnt;
   logic [TMO_W-1:0]  wdog;
   logic [NUM_CH-1:0] done_nxt;
   logic              has_above, wd_exp, go, unused;
   assign busy        = state == S_ISSUE || state == S_WAIT || state == S_GAP;
   assign go          = start && !busy;
   assign rd_req_vld  = state == S_ISSUE;
   assign rd_req_addr = CSR_BASE + ADDR_W'(idx) * CSR_STRIDE;
   // Watchdog counts as expired on the cycle it reaches zero and every cycle after.
   assign wd_exp      = wdog <= TMO_W'(1);
   assign unused      = ^rd_rsp_data;
   always_comb begin
      done_nxt   = ch_done;
      lo_free    = '0;
      above_free = '0;
      has_above  = 1'b0;
      if (state == S_WAIT && rd_rsp_vld && rd_rsp_data[0]) done_nxt[idx] = 1'b1;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (!done_nxt[i]) lo_free = IDX_W'(i);
         if (!done_nxt[i] && i > int'(idx)) begin
            above_free = IDX_W'(i);
            has_above  = 1'b1;
         end
      end
   end
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         S_IDLE, S_DONE, S_TMO: if (start) begin
            state_nxt = S_ISSUE;
            idx_nxt   = '0;
         end
         S_ISSUE: state_nxt = rd_req_rdy ? S_WAIT : S_ISSUE;
         S_WAIT: if (rd_rsp_vld) begin
            state_nxt = &done_nxt ? S_DONE : wd_exp ? S_TMO : has_above ? S_ISSUE : S_GAP;
            idx_nxt   = has_above ? above_free : idx;
         end
         S_GAP: if (wd_exp) state_nxt = S_TMO;
            else if (gap_cnt == GAP_W'(POLL_GAP - 1)) begin
               state_nxt = S_ISSUE;
               idx_nxt   = lo_free;
            end
         default: state_nxt = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         idx      <= '0;
         gap_cnt  <= '0;
         wdog     <= '0;
         ch_done  <= '0;
         all_done <= 1'b0;
         tmo_err  <= 1'b0;
         elapsed  <= '0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         gap_cnt  <= state == S_GAP ? gap_cnt + GAP_W'(1) : '0;
         wdog     <= go ? tmo_cfg : (busy && wdog != '0) ? wdog - TMO_W'(1) : wdog;
         ch_done  <= go ? '0 : done_nxt;
         all_done <= state_nxt == S_DONE;
         tmo_err  <= state_nxt == S_TMO;
         elapsed  <= go ? '0 : (busy && ~&elapsed) ? elapsed + TMO_W'(1) : elapsed;
      end
   end
endmodule
